// File: rtl/hamming_corr_pkg.sv
// Shared ECC types and helpers for the SECDED correction stage.
// Codeword index 0 is overall parity; indices 1..71 are Hamming positions.
package hamming_corr_pkg;

    localparam int ECC_DATA_W = 64;
    localparam int ECC_CW_W   = 72;
    localparam int ECC_SYN_W  = 8;

    typedef logic [ECC_CW_W-1:0]  pattern_t;
    typedef logic [ECC_SYN_W-1:0] parity_t;

    typedef struct packed {
        logic [ECC_DATA_W-1:0] data;
        logic                  sec;
        logic                  ded;
    } corr_t;

    // Data bits are the non-power-of-two positions, packed in ascending order.
    function automatic logic [ECC_DATA_W-1:0] cw_to_data(input pattern_t cw);
        logic [ECC_DATA_W-1:0] d;
        int                    j;
        d = {ECC_DATA_W{1'b0}};
        j = 32'sd0;
        for (int k = 32'sd1; k < ECC_CW_W; k++) begin
            if ((k & (k - 32'sd1)) != 32'sd0) begin
                d[j] = cw[k];
                j    = j + 32'sd1;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Classify a syndrome and produce the (possibly corrected) payload.
    function automatic corr_t ecc_correct(input pattern_t cw, input parity_t syn);
        corr_t      res;
        pattern_t   fixed;
        logic [6:0] s;
        logic       p;
        s     = syn[6:0];
        p     = syn[7];
        fixed = cw;
        res   = '0;
        if (!p) begin
            if (s != 7'd0) begin
                res.ded = 1'b1;
            end else begin
                res.ded = 1'b0;
            end
        end else if (s == 7'd0) begin
            res.sec = 1'b1;
        end else if (s < 7'd72) begin
            fixed[s] = ~fixed[s];
            res.sec  = 1'b1;
        end else begin
            res.ded = 1'b1;
        end
        res.data = cw_to_data(fixed);
        return res;
    endfunction

endpackage

// File: rtl/ecc_sync_fifo.sv
// Synchronous FIFO aligning received codewords with their late-arriving syndromes.
// The caller guarantees push/pop legality; a count register tracks occupancy.
module ecc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_BITS-1:0] count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_BITS'(1'b1);
                2'b01:   count_r <= count_r - CNT_BITS'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) mem_r[wr_ptr_r] <= wdata;
    end

    // Head-of-queue and status decode.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        full  = (count_r == CNT_BITS'(DEPTH));
        empty = (count_r == {CNT_BITS{1'b0}});
    end

endmodule

// File: rtl/hamming_corr.sv
// SECDED correction stage: queues codewords until hamming_dec delivers the
// syndrome, then corrects/flags them and keeps saturating event counters.
module hamming_corr
    import hamming_corr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  pattern_t              i_pattern,
    input  logic                  i_pattern_valid,
    input  parity_t               i_parity,
    input  logic                  i_parity_valid,
    input  logic                  i_cnt_clr,
    output logic [ECC_DATA_W-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_sec,
    output logic                  o_ded,
    output logic                  o_ovf,
    output logic                  o_unf,
    output logic [CNT_W-1:0]      o_cnt_sec,
    output logic [CNT_W-1:0]      o_cnt_ded
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic     push_req_s;
    logic     pop_req_s;
    logic     push_ok_s;
    logic     pop_ok_s;
    logic     fifo_full_s;
    logic     fifo_empty_s;
    pattern_t fifo_head_s;
    corr_t    corr_s;

    logic [ECC_DATA_W-1:0] data_r;
    logic                  valid_r;
    logic                  sec_r;
    logic                  ded_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic [CNT_W-1:0]      cnt_sec_r;
    logic [CNT_W-1:0]      cnt_ded_r;

    // A push into a full FIFO is accepted only when a pop frees the slot;
    // a syndrome against an empty FIFO never bypasses a same-cycle push.
    always_comb begin
        push_req_s = i_en & i_pattern_valid;
        pop_req_s  = i_en & i_parity_valid;
        pop_ok_s   = pop_req_s & ~fifo_empty_s;
        push_ok_s  = push_req_s & (~fifo_full_s | pop_ok_s);
        corr_s     = ecc_correct(fifo_head_s, i_parity);
    end

    ecc_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ECC_CW_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_ok_s),
        .pop   (pop_ok_s),
        .wdata (i_pattern),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Result registers: single-cycle valid pulse, payload held while idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_r  <= {ECC_DATA_W{1'b0}};
            valid_r <= 1'b0;
            sec_r   <= 1'b0;
            ded_r   <= 1'b0;
        end else begin
            valid_r <= pop_ok_s;
            sec_r   <= pop_ok_s & corr_s.sec;
            ded_r   <= pop_ok_s & corr_s.ded;
            if (pop_ok_s) begin
                data_r <= corr_s.data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (push_req_s && fifo_full_s && !pop_ok_s) ovf_r <= 1'b1;
            if (pop_req_s && fifo_empty_s)              unf_r <= 1'b1;
        end
    end

    // Saturating event counters; clear wins over a same-cycle event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_sec_r <= {CNT_W{1'b0}};
            cnt_ded_r <= {CNT_W{1'b0}};
        end else if (i_cnt_clr) begin
            cnt_sec_r <= {CNT_W{1'b0}};
            cnt_ded_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_ok_s && corr_s.sec && cnt_sec_r != CNT_MAX)
                cnt_sec_r <= cnt_sec_r + CNT_W'(1'b1);
            if (pop_ok_s && corr_s.ded && cnt_ded_r != CNT_MAX)
                cnt_ded_r <= cnt_ded_r + CNT_W'(1'b1);
        end
    end

    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_sec     = sec_r;
    assign o_ded     = ded_r;
    assign o_ovf     = ovf_r;
    assign o_unf     = unf_r;
    assign o_cnt_sec = cnt_sec_r;
    assign o_cnt_ded = cnt_ded_r;

endmodule

// File: tb/tb_hamming_corr.sv
// Self-checking bench for hamming_corr: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_hamming_corr;
    import hamming_corr_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;

    logic           clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_en = 1'b0;
    pattern_t       i_pattern = '0;
    logic           i_pattern_valid = 1'b0;
    parity_t        i_parity = '0;
    logic           i_parity_valid = 1'b0;
    logic           i_cnt_clr = 1'b0;
    logic [63:0]    o_data;
    logic           o_valid, o_sec, o_ded, o_ovf, o_unf;
    logic [CW-1:0]  o_cnt_sec, o_cnt_ded;

    always #5 clk = ~clk;

    hamming_corr #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_pattern(i_pattern), .i_pattern_valid(i_pattern_valid),
        .i_parity(i_parity), .i_parity_valid(i_parity_valid),
        .i_cnt_clr(i_cnt_clr), .o_data(o_data), .o_valid(o_valid),
        .o_sec(o_sec), .o_ded(o_ded), .o_ovf(o_ovf), .o_unf(o_unf),
        .o_cnt_sec(o_cnt_sec), .o_cnt_ded(o_cnt_ded));

    int checks = 0;
    int errors = 0;

    // reference model state
    pattern_t      mq[$];
    logic          ev, es, edd, eovf, eunf;
    logic [63:0]   ed;
    logic [CW-1:0] ecs, ecd;

    function automatic logic [63:0] ref_data(input pattern_t cw);
        logic [63:0] d = '0;
        int j = 0;
        for (int k = 1; k < 72; k++)
            if ($countones(k) != 1) begin d[j] = cw[k]; j++; end
        return d;
    endfunction

    function automatic pattern_t encode(input logic [63:0] d);
        pattern_t cw = '0;
        logic [6:0] s = '0;
        int j = 0;
        for (int k = 1; k < 72; k++)
            if ($countones(k) != 1) begin
                cw[k] = d[j]; j++;
                if (cw[k]) s = s ^ k[6:0];
            end
        for (int i = 0; i < 7; i++) cw[1 << i] = s[i];
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    function automatic parity_t syn_of(input pattern_t cw);
        logic [6:0] s = '0;
        for (int k = 1; k < 72; k++) if (cw[k]) s = s ^ k[6:0];
        return {^cw, s};
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic apply(input logic en, input logic pv, input pattern_t pat,
                         input logic sv, input parity_t syn, input logic clr);
        logic do_pop, do_push;
        pattern_t h;
        logic [6:0] s;
        logic p;
        i_en = en; i_pattern_valid = pv; i_pattern = pat;
        i_parity_valid = sv; i_parity = syn; i_cnt_clr = clr;
        do_pop  = en && sv && mq.size() != 0;
        do_push = en && pv && (mq.size() < DEPTH || do_pop);
        if (en && pv && mq.size() == DEPTH && !do_pop) eovf = 1'b1;
        if (en && sv && mq.size() == 0) eunf = 1'b1;
        ev = do_pop; es = 1'b0; edd = 1'b0;
        if (do_pop) begin
            h = mq.pop_front();
            s = syn[6:0]; p = syn[7];
            if (p && s != 0 && s < 72) h[s] = ~h[s];
            es  = p && (s < 72);
            edd = (p && s >= 72) || (!p && s != 0);
            ed  = ref_data(h);
        end
        if (do_push) mq.push_back(pat);
        if (clr) begin ecs = '0; ecd = '0; end
        else begin
            if (es && ecs != 2'd3) ecs = ecs + 2'd1;
            if (edd && ecd != 2'd3) ecd = ecd + 2'd1;
        end
        tick();
    endtask

    task automatic do_reset;
        i_rst_n = 1'b0; i_en = 1'b0; i_pattern_valid = 1'b0;
        i_parity_valid = 1'b0; i_cnt_clr = 1'b0;
        tick();
        i_rst_n = 1'b1;
        mq.delete();
        ev = 0; es = 0; edd = 0; eovf = 0; eunf = 0; ed = '0; ecs = '0; ecd = '0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({o_valid, o_sec, o_ded, o_ovf, o_unf} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {o_valid, o_sec, o_ded, o_ovf, o_unf});
        end
        checks++;
        if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
        checks++;
        if ({o_cnt_sec, o_cnt_ded} !== 4'b0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", o_cnt_sec, o_cnt_ded);
        end
    endtask

    task automatic test_clean;
        pattern_t c = encode(D0);
        apply(1, 1, c, 0, 8'h00, 0);
        apply(1, 0, '0, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b100 || o_data !== D0) begin
            errors++; $display("FAIL clean got v%b s%b d%b %h want v1 s0 d0 %h", o_valid, o_sec, o_ded, o_data, D0);
        end
        checks++;
        if ({o_cnt_sec, o_cnt_ded} !== 4'b0) begin
            errors++; $display("FAIL clean_cnt got %0d/%0d want 0/0", o_cnt_sec, o_cnt_ded);
        end
        apply(1, 0, '0, 0, 8'h00, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b000 || o_data !== D0) begin
            errors++; $display("FAIL hold got v%b %h want v0 %h", o_valid, o_data, D0);
        end
    endtask

    task automatic test_sec;
        pattern_t c = encode(D0);
        pattern_t cx = c;
        cx[3] = ~cx[3];
        apply(1, 1, cx, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h83, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b110 || o_data !== D0 || o_cnt_sec !== 2'd1) begin
            errors++; $display("FAIL sec_flip got v%b s%b d%b %h cnt%0d want v1 s1 d0 %h cnt1",
                               o_valid, o_sec, o_ded, o_data, o_cnt_sec, D0);
        end
        apply(1, 1, c, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h80, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b110 || o_data !== D0 || o_cnt_sec !== 2'd2) begin
            errors++; $display("FAIL sec_overall got v%b s%b d%b %h cnt%0d want v1 s1 d0 %h cnt2",
                               o_valid, o_sec, o_ded, o_data, o_cnt_sec, D0);
        end
    endtask

    task automatic test_ded;
        pattern_t c = encode(D0);
        apply(1, 1, c, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h05, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b101 || o_data !== D0 || o_cnt_ded !== 2'd1) begin
            errors++; $display("FAIL ded_even got v%b s%b d%b %h cnt%0d want v1 s0 d1 %h cnt1",
                               o_valid, o_sec, o_ded, o_data, o_cnt_ded, D0);
        end
        apply(1, 1, c, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'hC8, 0);
        checks++;
        if ({o_valid, o_sec, o_ded} !== 3'b101 || o_cnt_ded !== 2'd2) begin
            errors++; $display("FAIL ded_range got v%b s%b d%b cnt%0d want v1 s0 d1 cnt2",
                               o_valid, o_sec, o_ded, o_cnt_ded);
        end
        apply(1, 0, '0, 0, 8'h00, 1);
        checks++;
        if ({o_cnt_sec, o_cnt_ded} !== 4'b0) begin
            errors++; $display("FAIL cnt_clr got %0d/%0d want 0/0", o_cnt_sec, o_cnt_ded);
        end
    endtask

    task automatic test_overflow;
        pattern_t pats[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pats[i] = {$urandom, $urandom, $urandom};
            apply(1, 1, pats[i], 0, 8'h00, 0);
        end
        checks++;
        if (o_ovf !== 1'b1 || o_unf !== 1'b0) begin
            errors++; $display("FAIL ovf_set got ovf%b unf%b want ovf1 unf0", o_ovf, o_unf);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, '0, 1, 8'h00, 0);
            checks++;
            if (o_valid !== 1'b1 || o_data !== ref_data(pats[i])) begin
                errors++; $display("FAIL ovf_drain%0d got v%b %h want v1 %h", i, o_valid, o_data, ref_data(pats[i]));
            end
        end
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b0 || o_unf !== 1'b1) begin
            errors++; $display("FAIL ovf_fifth got v%b unf%b want v0 unf1", o_valid, o_unf);
        end
    endtask

    task automatic test_full_push_pop;
        pattern_t pats[5];
        do_reset();
        for (int i = 0; i < 5; i++) pats[i] = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) apply(1, 1, pats[i], 0, 8'h00, 0);
        apply(1, 1, pats[4], 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== ref_data(pats[0]) || o_ovf !== 1'b0) begin
            errors++; $display("FAIL full_pushpop got v%b %h ovf%b want v1 %h ovf0", o_valid, o_data, o_ovf, ref_data(pats[0]));
        end
        for (int i = 1; i < 5; i++) begin
            apply(1, 0, '0, 1, 8'h00, 0);
            checks++;
            if (o_valid !== 1'b1 || o_data !== ref_data(pats[i])) begin
                errors++; $display("FAIL full_drain%0d got v%b %h want v1 %h", i, o_valid, o_data, ref_data(pats[i]));
            end
        end
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b0 || o_ovf !== 1'b0 || o_unf !== 1'b1) begin
            errors++; $display("FAIL full_count got v%b ovf%b unf%b want v0 ovf0 unf1", o_valid, o_ovf, o_unf);
        end
    endtask

    task automatic test_enable;
        pattern_t p = {$urandom, $urandom, $urandom};
        pattern_t q = {$urandom, $urandom, $urandom};
        do_reset();
        apply(1, 1, p, 0, 8'h00, 0);
        apply(0, 1, q, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b0 || o_unf !== 1'b0) begin
            errors++; $display("FAIL en_low got v%b unf%b want v0 unf0", o_valid, o_unf);
        end
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== ref_data(p)) begin
            errors++; $display("FAIL en_retain got v%b %h want v1 %h", o_valid, o_data, ref_data(p));
        end
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b0 || o_unf !== 1'b1) begin
            errors++; $display("FAIL en_nopush got v%b unf%b want v0 unf1", o_valid, o_unf);
        end
    endtask

    task automatic test_saturation;
        pattern_t cx = encode(D0);
        cx[3] = ~cx[3];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, cx, 0, 8'h00, 0);
            apply(1, 0, '0, 1, 8'h83, 0);
        end
        checks++;
        if (o_cnt_sec !== 2'd3) begin errors++; $display("FAIL sat got %0d want 3", o_cnt_sec); end
        apply(1, 1, cx, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h83, 1);
        checks++;
        if (o_sec !== 1'b1 || o_cnt_sec !== 2'd0) begin
            errors++; $display("FAIL clr_prio got sec%b cnt%0d want sec1 cnt0", o_sec, o_cnt_sec);
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        for (int i = 0; i < 3; i++) apply(1, 1, {$urandom, $urandom, $urandom}, 0, 8'h00, 0);
        apply(1, 0, '0, 1, 8'h83, 0);
        do_reset();
        checks++;
        if ({o_valid, o_sec, o_ded, o_ovf, o_unf, o_cnt_sec, o_cnt_ded} !== 9'b0 || o_data !== 64'h0) begin
            errors++; $display("FAIL rst_mid got v%b s%b d%b ovf%b unf%b cnt%0d/%0d %h want all 0",
                               o_valid, o_sec, o_ded, o_ovf, o_unf, o_cnt_sec, o_cnt_ded, o_data);
        end
        apply(1, 0, '0, 1, 8'h00, 0);
        checks++;
        if (o_valid !== 1'b0 || o_unf !== 1'b1) begin
            errors++; $display("FAIL rst_mid_unf got v%b unf%b want v0 unf1", o_valid, o_unf);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] orig[$];
        logic [63:0] d, want;
        pattern_t c;
        parity_t syn;
        do_reset();
        d = {$urandom, $urandom}; orig.push_back(d);
        c = encode(d); c[$urandom_range(71, 0)] ^= 1'b1;
        apply(1, 1, c, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            syn = syn_of(mq[0]);
            d = {$urandom, $urandom}; orig.push_back(d);
            c = encode(d); c[$urandom_range(71, 0)] ^= 1'b1;
            apply(1, 1, c, 1, syn, 0);
            want = orig.pop_front();
            checks++;
            if (o_valid !== 1'b1 || o_sec !== 1'b1 || o_ded !== 1'b0 || o_data !== want) begin
                errors++; $display("FAIL b2b%0d got v%b s%b d%b %h want v1 s1 d0 %h", i, o_valid, o_sec, o_ded, o_data, want);
            end
        end
    endtask

    task automatic test_random;
        pattern_t c;
        parity_t syn;
        int nflip;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            c = encode({$urandom, $urandom});
            nflip = $urandom_range(2, 0);
            for (int f = 0; f < nflip; f++) c[$urandom_range(71, 0)] ^= 1'b1;
            if (mq.size() != 0 && $urandom_range(9, 0) < 8) syn = syn_of(mq[0]);
            else syn = parity_t'($urandom);
            apply($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, c,
                  $urandom_range(1, 0) == 1, syn, $urandom_range(49, 0) == 0);
            checks++;
            if ({o_valid, o_sec, o_ded} !== {ev, es, edd} || o_data !== ed ||
                {o_ovf, o_unf} !== {eovf, eunf} || {o_cnt_sec, o_cnt_ded} !== {ecs, ecd}) begin
                errors++;
                $display("FAIL rand%0d got v%b s%b d%b %h o%b u%b c%0d/%0d want v%b s%b d%b %h o%b u%b c%0d/%0d",
                         i, o_valid, o_sec, o_ded, o_data, o_ovf, o_unf, o_cnt_sec, o_cnt_ded,
                         ev, es, edd, ed, eovf, eunf, ecs, ecd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_sec();
        test_ded();
        test_overflow();
        test_full_push_pop();
        test_enable();
        test_saturation();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_corr.md
Name: hamming_corr

Overview:
- SECDED correction stage directly downstream of hamming_dec. Consumes the syndrome that hamming_dec produces on o_parity/o_valid.
- Holds each received codeword in a small alignment FIFO until its syndrome arrives.
- Flips the single erroneous bit, or flags a double error.
- Emits the 64-bit payload with status, plus saturating error counters for the CSR block.

Parameters:
- FIFO_DEPTH, 4, alignment FIFO entries (power of 2, 2..16); must cover the hamming_dec latency.
- CNT_W, 16, width of the SEC/DED event counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_en  in  1  block enable; when low, no push, no pop, no output
- i_pattern  in  pattern_t (72)  received codeword; the same bus that feeds hamming_dec
- i_pattern_valid  in  1  push i_pattern into the FIFO
- i_parity  in  parity_t (8)  syndrome from hamming_dec o_parity
- i_parity_valid  in  1  syndrome valid (hamming_dec o_valid); pops the FIFO
- i_cnt_clr  in  1  synchronous clear of both counters
- o_data  out  64  corrected payload
- o_valid  out  1  o_data/o_sec/o_ded valid, one-cycle pulse
- o_sec  out  1  single error corrected (includes overall-parity-bit error)
- o_ded  out  1  uncorrectable error; o_data is the uncorrected payload
- o_ovf  out  1  sticky: push dropped because the FIFO was full
- o_unf  out  1  sticky: syndrome arrived with the FIFO empty
- o_cnt_sec  out  CNT_W  saturating count of o_sec events
- o_cnt_ded  out  CNT_W  saturating count of o_ded events

Behaviour:
- Reset (i_rst_n=0 at posedge): FIFO empty, pointers 0, and every output is 0, including o_data, the stickies and the counters. Reset mid-stream discards all queued codewords.
- Codeword layout:
  - index 0 = overall parity.
  - Index k (1..71) = Hamming position k.
  - Check bits sit at k = 1,2,4,8,16,32,64.
  - Data bits occupy the remaining 64 positions in ascending k order, giving o_data[0]..o_data[63].
- Syndrome layout: s = i_parity[6:0], p = i_parity[7] (overall parity mismatch).
- Classification:
  - s=0, p=0: clean.
  - p=1, s=0: overall bit error; payload unchanged; o_sec=1.
  - p=1, 1≤s≤71: flip index s; o_sec=1.
  - p=1, s≥72: o_ded=1.
  - p=0, s≠0: o_ded=1.
- Pop/output: if i_en=1 and i_parity_valid=1 with the FIFO non-empty, pop the head and correct it against i_parity. Results are registered: o_valid, o_data, o_sec and o_ded are asserted the next cycle (latency 1 from the syndrome).
- Push: if i_en=1 and i_pattern_valid=1, write at the tail.
- Push to a full FIFO:
  - With a simultaneous pop: legal; the pop frees the slot and the count is unchanged.
  - Without a pop: drop the codeword and set o_ovf.
- Pop from an empty FIFO: applies to a syndrome with the FIFO empty, including a same-cycle push into the empty FIFO. No bypass: the push is written, nothing is output, and o_unf is set.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with a count register of width log2(FIFO_DEPTH)+1.
- i_en=0: inputs are ignored, FIFO contents and flags are retained, and o_valid=0 the next cycle.
- Counters:
  - Each counter increments by 1 on its event and saturates at 2^CNT_W-1.
  - i_cnt_clr zeros both counters and takes priority over a same-cycle increment.
  - o_ovf/o_unf clear only on reset.
- o_sec and o_ded are never both 1. When o_valid=0, o_sec=o_ded=0 and o_data holds its last value.

Decomposition:
- pattern_t (72b) and parity_t (8b) stay in the shared define.sv typedef set.
- Add to define.sv: ECC_DATA_W=64, ECC_CW_W=72, ECC_SYN_W=8, and a function cw_to_data(pattern_t) returning the 64-bit payload extraction.
- One sub-module is natural: ecc_sync_fifo (parameterised depth/width, push/pop, full/empty/count). The correction datapath stays in hamming_corr.

Test Plan:
- Clean: push codeword C (valid encoding of data 0x0123_4567_89AB_CDEF); 2 cycles later drive syndrome 0x00 → next cycle o_valid=1, o_data=0x0123456789ABCDEF, o_sec=o_ded=0, counters unchanged.
- SEC: push C with index 3 flipped (data bit 0); drive syndrome 0x83 → o_data=0x0123456789ABCDEF, o_sec=1, o_cnt_sec=1. Repeat with syndrome 0x80 → o_sec=1, data unchanged.
- DED: push C; drive syndrome 0x05 → o_ded=1, o_data = raw payload, o_cnt_ded=1. Syndrome 0xC8 (s=72, p=1) → o_ded=1.
- Full/overflow: push 4 codewords without pops, then push a 5th → o_ovf=1. Then 4 syndromes of 0x00 → exactly 4 outputs in push order, and the 5th codeword is absent. Separately, full FIFO + push + pop in the same cycle → no o_ovf, count stays 4.
- Underflow / i_en: with the FIFO empty, drive syndrome 0x00 → no o_valid, o_unf=1. With i_en=0, drive push+syndrome → no FIFO change, no o_valid.
- Saturation / reset: CNT_W=2, 5 SEC events → o_cnt_sec=3. i_cnt_clr concurrent with a SEC event → 0. Assert i_rst_n=0 with 3 entries queued → all outputs 0, and the next syndrome sets o_unf.
